mmio_timer: RTL

Memory-mapped down-counting timer that acts as a responder on the CPU data-memory bus (address, write/read strobe, write data, read data). It decodes a fixed address window, accepts word writes, and returns read data one cycle after the request, matching main-memory read latency. Its read data is OR-combined with memory read data ahead of the MDR and IR, and its irq output feeds the exception logic.

---
 rtl/mmio_timer_pkg.sv | 31 +++
 rtl/mmio_timer_if.sv | 10 +
 rtl/mmio_timer_prescaler.sv | 24 ++
 rtl/mmio_timer.sv | 105 ++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer.
// Holds the register offsets, bit positions and run-mode decode.
package timer_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_FF00;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_COUNT  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_PRESC  = 5'h10;

    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned AUTO_BIT = 1;
    localparam int unsigned IE_BIT   = 2;
    localparam int unsigned EXP_BIT  = 0;

    typedef enum logic [1:0] {
        STOPPED      = 2'd0,
        RUN_ONESHOT  = 2'd1,
        RUN_PERIODIC = 2'd2
    } mode_t;

    // The run mode is not separate state; it is fully implied by EN/AUTO.
    function automatic mode_t mode_of(input logic en, input logic auto_rl);
        if (!en)
            return STOPPED;
        return auto_rl ? RUN_PERIODIC : RUN_ONESHOT;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-memory bus as seen by the timer: address, strobe, store and read data.
interface mmio_timer_if;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wr, output wdata, input rdata);
    modport slave  (input addr, input wr, input wdata, output rdata);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Clock prescaler: emits one tick every PRESC+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcnt <= '0;
        else if (clr || tick)
            pcnt <= '0;
        else if (en)
            pcnt <= pcnt + PRESC_W'(1);
    end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer on the CPU data bus with one-cycle read latency.
// Bus writes take priority over any same-edge tick or expiry update, except the EXP set.
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);
    logic [2:0]         ctrl;
    logic [31:0]        load;
    logic [31:0]        count;
    logic               expd;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        rdata_q;
    logic [31:0]        rd_val;

    logic       hit, wr_hit, rd_hit;
    logic [4:0] off;
    logic       wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    logic       tick, expire;
    mode_t      mode;
    logic       addr_unused;

    assign hit         = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign wr_hit      = hit && bus.wr;
    assign rd_hit      = hit && !bus.wr;
    assign off         = {bus.addr[4:2], 2'b00};
    assign addr_unused = ^bus.addr[1:0];

    assign wr_ctrl   = wr_hit && (off == OFF_CTRL);
    assign wr_load   = wr_hit && (off == OFF_LOAD);
    assign wr_count  = wr_hit && (off == OFF_COUNT);
    assign wr_status = wr_hit && (off == OFF_STATUS);
    assign wr_presc  = wr_hit && (off == OFF_PRESC);

    assign mode   = mode_of(ctrl[EN_BIT], ctrl[AUTO_BIT]);
    assign expire = tick && (count == '0);

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl[EN_BIT]),
        .clr   (wr_ctrl || wr_count),
        .presc (presc),
        .tick  (tick)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CTRL:   rd_val[2:0]         = ctrl;
            OFF_LOAD:   rd_val              = load;
            OFF_COUNT:  rd_val              = count;
            OFF_STATUS: rd_val[EXP_BIT]     = expd;
            OFF_PRESC:  rd_val[PRESC_W-1:0] = presc;
            default:    rd_val              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expd    <= 1'b0;
            presc   <= '0;
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_hit ? rd_val : '0;

            if (wr_ctrl)
                ctrl <= bus.wdata[2:0];
            else if (expire && mode == RUN_ONESHOT)
                ctrl[EN_BIT] <= 1'b0;

            if (wr_load)
                load <= bus.wdata;
            if (wr_presc)
                presc <= bus.wdata[PRESC_W-1:0];

            // Zero never decrements: it either reloads or parks at zero.
            if (wr_count)
                count <= bus.wdata;
            else if (tick) begin
                if (count != '0)
                    count <= count - 32'd1;
                else if (mode == RUN_PERIODIC)
                    count <= load;
            end

            if (expire)
                expd <= 1'b1;
            else if (wr_status && bus.wdata[EXP_BIT])
                expd <= 1'b0;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq       = expd && ctrl[IE_BIT];
endmodule
